instr_fetch: RTL and testbench

- Responder side of the sequencer's PC strobe interface.
- Owns the program counter and the instruction register (IR), and fetches from instruction memory through a valid handshake.
- Presents opcode, operand fields and immediate to the control sequencer and register file.
- Advances or redirects the PC when the sequencer pulses c_pc_inc or c_pc_load.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/instr_fetch_if.sv | 16 +
 rtl/instr_fetch_pc_counter.sv | 20 ++
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, widths and
// the fetch FSM encoding.
package cpu_pkg;
    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_ADDI = 4'h2, OP_ROW  = 4'h3,
        OP_COL  = 4'h4, OP_INCL = 4'h5, OP_F    = 4'h6, OP_LD   = 4'h7,
        OP_ST   = 4'h8, OP_LDI  = 4'h9, OP_LFSR = 4'hA, OP_JE   = 4'hB,
        OP_JNE  = 4'hC, OP_J    = 4'hD
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: one-cycle request, data returned later
// qualified by rvalid.
interface instr_fetch_if
    import cpu_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();
    logic [PC_W-1:0]    addr;
    logic               rd_en;
    logic [INSTR_W-1:0] rdata;
    logic               rvalid;

    modport master (output addr, output rd_en, input rdata, input rvalid);
    modport slave  (input addr, input rd_en, output rdata, output rvalid);
endinterface

// File: rtl/instr_fetch_pc_counter.sv
// Program counter register; a load beats an increment when both are asked for.
module pc_counter #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (reset)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns PC and IR, fetches through the imem handshake and
// advances/redirects the PC on sequencer strobes while READY.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_pc_inc,
    input  logic             c_pc_load,
    input  logic             c_a,
    input  logic             c_b,
    instr_fetch_if.master    imem,
    output logic [3:0]       opcode,
    output logic [3:0]       ra,
    output logic [3:0]       rb,
    output logic [7:0]       imm,
    output logic [3:0]       reg_addr,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc,
    output logic             seq_err
);
    fetch_state_t       state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               strobe, step;

    assign strobe = c_pc_inc | c_pc_load;
    assign step   = strobe && (state == READY);

    pc_counter #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc      (c_pc_inc && step),
        .load     (c_pc_load && step),
        .load_val (ir[PC_W-1:0]),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   state_nxt = WAIT;
            WAIT:    if (imem.rvalid) state_nxt = READY;
            READY:   if (strobe) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Gate the request with reset so nothing is issued while memory is held in reset.
    assign imem.rd_en = (state == FETCH) && !reset;
    assign imem.addr  = pc;
    assign instr_valid = (state == READY);

    always_ff @(posedge clk) begin
        if (reset)
            ir <= '0;
        else if (state == WAIT && imem.rvalid)
            ir <= imem.rdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            seq_err <= 1'b0;
        else if (strobe && state != READY)
            seq_err <= 1'b1;
    end

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

    always_comb begin
        reg_addr = 4'd0;
        if (c_a)
            reg_addr = ra;
        else if (c_b)
            reg_addr = rb;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a reset-aware variable-latency memory model.
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       c_pc_inc = 1'b0, c_pc_load = 1'b0, c_a = 1'b0, c_b = 1'b0;
    logic [3:0] opcode, ra, rb, reg_addr;
    logic [7:0] imm, pc;
    logic       instr_valid, seq_err;

    logic [15:0] mem [256];
    int          lat = 1;
    logic        pend, mrvalid, spur = 1'b0;
    int          cnt;
    logic [7:0]  paddr;
    logic [15:0] mrdata, spur_data = 16'h0;

    int n_chk = 0;
    int n_err = 0;

    instr_fetch_if imem ();

    instr_fetch dut (
        .clk(clk), .reset(reset), .c_pc_inc(c_pc_inc), .c_pc_load(c_pc_load),
        .c_a(c_a), .c_b(c_b), .imem(imem), .opcode(opcode), .ra(ra), .rb(rb),
        .imm(imm), .reg_addr(reg_addr), .instr_valid(instr_valid), .pc(pc),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Memory model: request at cycle k answers with rvalid at cycle k+lat.
    always @(posedge clk) begin
        mrvalid <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (imem.rd_en) begin
            if (lat == 1) begin
                mrvalid <= 1'b1;
                mrdata  <= mem[imem.addr];
            end else begin
                pend  <= 1'b1;
                cnt   <= lat - 1;
                paddr <= imem.addr;
            end
        end else if (pend) begin
            if (cnt == 1) begin
                mrvalid <= 1'b1;
                mrdata  <= mem[paddr];
                pend    <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    assign imem.rvalid = mrvalid | spur;
    assign imem.rdata  = spur ? spur_data : mrdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_strobe(input logic inc, input logic load);
        c_pc_inc  = inc;
        c_pc_load = load;
        tick();
        c_pc_inc  = 1'b0;
        c_pc_load = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_cyc);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, exp_cyc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h00] = 16'h1234;
        mem[8'h34] = 16'hE005;
        mem[8'h05] = 16'h0000;
        mem[8'h06] = 16'hF02A;
        mem[8'h2A] = 16'h10FF;
        mem[8'hFF] = 16'h2000;
        mem[8'h01] = 16'h5010;

        tick();
        tick();
        chk("rst_pc", pc, 8'h00);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_rd_en", imem.rd_en, 1'b0);
        chk("rst_addr", imem.addr, 8'h00);
        chk("rst_seq_err", seq_err, 1'b0);

        // First fetch, memory latency 1
        reset = 1'b0;
        #1;
        chk("c1_rd_en", imem.rd_en, 1'b1);
        chk("c1_addr", imem.addr, 8'h00);
        tick();
        chk("c2_rd_en", imem.rd_en, 1'b0);
        chk("c2_valid", instr_valid, 1'b0);
        tick();
        chk("c3_valid", instr_valid, 1'b1);
        chk("c3_opcode", opcode, 4'h1);
        chk("c3_ra", ra, 4'h2);
        chk("c3_rb", rb, 4'h3);
        chk("c3_imm", imm, 8'h34);

        c_a = 1'b1; #1; chk("regaddr_a", reg_addr, 4'h2);
        c_b = 1'b1; #1; chk("regaddr_ab", reg_addr, 4'h2);
        c_a = 1'b0; #1; chk("regaddr_b", reg_addr, 4'h3);
        c_b = 1'b0; #1; chk("regaddr_none", reg_addr, 4'h0);

        // Load to 0x34, then load to 5
        do_strobe(1'b0, 1'b1);
        chk("ld34_pc", pc, 8'h34);
        chk("ld34_addr", imem.addr, 8'h34);
        wait_valid("ld34_lat", 2);
        do_strobe(1'b0, 1'b1);
        chk("ld5_pc", pc, 8'h05);
        wait_valid("ld5_lat", 2);

        // Increment 5 -> 6 with memory latency 3
        lat = 3;
        do_strobe(1'b1, 1'b0);
        chk("inc_pc", pc, 8'h06);
        chk("inc_valid", instr_valid, 1'b0);
        chk("inc_addr", imem.addr, 8'h06);
        chk("inc_rd_en", imem.rd_en, 1'b1);
        wait_valid("inc_lat3", 4);
        chk("inc_opcode", opcode, 4'hF);

        // Both strobes: load wins
        do_strobe(1'b1, 1'b1);
        chk("both_pc", pc, 8'h2A);
        chk("both_addr", imem.addr, 8'h2A);
        wait_valid("both_lat", 4);
        do_strobe(1'b0, 1'b1);
        chk("ldff_pc", pc, 8'hFF);
        wait_valid("ldff_lat", 4);

        // Wrap 0xFF -> 0x00, then strobe during WAIT
        do_strobe(1'b1, 1'b0);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_addr", imem.addr, 8'h00);
        tick();
        c_pc_inc = 1'b1;
        tick();
        c_pc_inc = 1'b0;
        chk("err_pc", pc, 8'h00);
        chk("err_seq", seq_err, 1'b1);
        wait_valid("err_lat", 2);
        chk("err_opcode", opcode, 4'h1);
        do_strobe(1'b1, 1'b0);
        chk("post_err_pc", pc, 8'h01);
        chk("err_sticky", seq_err, 1'b1);
        wait_valid("post_err_lat", 4);
        chk("post_err_imm", imm, 8'h10);

        // rvalid outside WAIT must not touch IR
        spur = 1'b1;
        spur_data = 16'hAAAA;
        tick();
        spur = 1'b0;
        chk("spur_opcode", opcode, 4'h5);
        chk("spur_imm", imm, 8'h10);

        // Reset in the middle of WAIT at pc=0x10
        do_strobe(1'b0, 1'b1);
        chk("ld10_pc", pc, 8'h10);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_valid", instr_valid, 1'b0);
        chk("midrst_seq_err", seq_err, 1'b0);
        reset = 1'b0;
        #1;
        chk("refetch_rd_en", imem.rd_en, 1'b1);
        chk("refetch_addr", imem.addr, 8'h00);
        wait_valid("refetch_lat", 4);
        chk("refetch_opcode", opcode, 4'h1);
        chk("refetch_imm", imm, 8'h34);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
